// File: rtl/digiota_bitstream_decim_if.sv
// Result channel of the OTA bitstream decimator: registered count with a valid/ready
// handshake plus the sticky overrun flag and its clear.
interface digiota_bitstream_decim_if #(
   parameter int CNT_W = 9
);
   logic [CNT_W-1:0] dout;
   logic             dout_valid;
   logic             dout_ready;
   logic             ovr;
   logic             ovr_clr;

   modport master (
      output dout,
      output dout_valid,
      output ovr,
      input  dout_ready,
      input  ovr_clr
   );

   modport slave (
      input  dout,
      input  dout_valid,
      input  ovr,
      output dout_ready,
      output ovr_clr
   );
endinterface

// File: rtl/digiota_bitstream_decim.sv
// Counts ones of the synchronized OTA comparator stream over 2^WIN_LOG2-cycle windows into a
// one-entry output buffer. Define DECIM_GLITCH_FILTER_EN to add a 3-sample majority filter.
module digiota_bitstream_decim #(
   parameter int WIN_LOG2 = 8,
   parameter int CNT_W    = WIN_LOG2 + 1
) (
   input  logic clk,
   input  logic rst,
   input  logic ota_out,
   input  logic en,
   digiota_bitstream_decim_if.master out_if
);

   localparam logic [WIN_LOG2-1:0] WCNT_LAST = '1;
   localparam logic [WIN_LOG2-1:0] WCNT_ONE  = WIN_LOG2'(1);

   logic                s1_reg;
   logic                s2_reg;
   logic                b;
   logic [WIN_LOG2-1:0] wcnt_reg;
   logic [WIN_LOG2-1:0] wcnt_next;
   logic [CNT_W-1:0]    acc_reg;
   logic [CNT_W-1:0]    acc_next;
   logic [CNT_W-1:0]    result;
   logic [CNT_W-1:0]    dout_reg;
   logic [CNT_W-1:0]    dout_next;
   logic                dout_valid_reg;
   logic                dout_valid_next;
   logic                ovr_reg;
   logic                ovr_next;
   logic                close;
   logic                load;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_reg <= 1'b0;
         s2_reg <= 1'b0;
      end else begin
         s1_reg <= ota_out;
         s2_reg <= s1_reg;
      end
   end

`ifdef DECIM_GLITCH_FILTER_EN
   // s2 plus two delayed copies form the three-sample window; a lone 1 never wins the vote.
   logic [1:0] tap_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tap_reg <= '0;
      end else begin
         tap_reg <= {tap_reg[0], s2_reg};
      end
   end

   assign b = (s2_reg & tap_reg[0]) | (s2_reg & tap_reg[1]) | (tap_reg[0] & tap_reg[1]);
`else
   assign b = s2_reg;
`endif

   always_comb begin
      close  = en && (wcnt_reg == WCNT_LAST);
      result = acc_reg + {{(CNT_W-1){1'b0}}, b};
      load   = close && (!dout_valid_reg || out_if.dout_ready);

      // Dropping en clears the window so re-enabling always starts at slot 0.
      wcnt_next = en ? (wcnt_reg + WCNT_ONE) : '0;
      acc_next  = (en && !close) ? result : '0;

      dout_next       = dout_reg;
      dout_valid_next = dout_valid_reg;
      if (load) begin
         dout_next       = result;
         dout_valid_next = 1'b1;
      end else if (dout_valid_reg && out_if.dout_ready) begin
         dout_valid_next = 1'b0;
      end

      // A new overrun takes priority over a simultaneous clear.
      ovr_next = ovr_reg;
      if (close && !load) begin
         ovr_next = 1'b1;
      end else if (out_if.ovr_clr) begin
         ovr_next = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wcnt_reg       <= '0;
         acc_reg        <= '0;
         dout_reg       <= '0;
         dout_valid_reg <= 1'b0;
         ovr_reg        <= 1'b0;
      end else begin
         wcnt_reg       <= wcnt_next;
         acc_reg        <= acc_next;
         dout_reg       <= dout_next;
         dout_valid_reg <= dout_valid_next;
         ovr_reg        <= ovr_next;
      end
   end

   assign out_if.dout       = dout_reg;
   assign out_if.dout_valid = dout_valid_reg;
   assign out_if.ovr        = ovr_reg;

endmodule

// File: tb/tb_digiota_bitstream_decim.sv
// Bench for digiota_bitstream_decim with 16-cycle windows: density table through a result
// scoreboard, then backpressure, load/consume collision, abort and async reset sequences.
module tb_digiota_bitstream_decim;

   localparam int WIN_LOG2 = 4;
   localparam int CNT_W    = WIN_LOG2 + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ota_out = 1'b0;
   logic en = 1'b0;

   digiota_bitstream_decim_if #(.CNT_W(CNT_W)) bus ();

   digiota_bitstream_decim #(
      .WIN_LOG2(WIN_LOG2),
      .CNT_W   (CNT_W)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .ota_out(ota_out),
      .en     (en),
      .out_if (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string name;
      int    pat;
      int    exp_first;
      int    exp_steady;
   } vec_t;

   vec_t vecs[4];
   int   exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   last_pop = -1;
   bit   mon_en = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Stimulus pattern: value of ota_out seen at edge k after enable.
   function automatic logic pat_bit(input int pat, input int k);
      case (pat)
         1:       return 1'b1;
         2:       return (k % 2) == 0;
         3:       return (k % 4) == 0;
         default: return 1'b0;
      endcase
   endfunction

   task automatic tick();
      int e;
      @(posedge clk);
      #1;
      cyc++;
      if (mon_en && bus.dout_valid && bus.dout_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", int'(bus.dout), -1);
         end else begin
            e = exp_q.pop_front();
            chk("sb_dout", int'(bus.dout), e);
            if (last_pop >= 0) chk("sb_interval", cyc - last_pop, 16);
            last_pop = cyc;
            $display("result dout=%0d expected=%0d cycle=%0d", bus.dout, e, cyc);
         end
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en = 1'b0;
      ota_out = 1'b0;
      bus.dout_ready = 1'b0;
      bus.ovr_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      vecs[0] = '{name: "const_high", pat: 1, exp_first: 14, exp_steady: 16};
      vecs[1] = '{name: "toggle",     pat: 2, exp_first: 7,  exp_steady: 8};
      vecs[2] = '{name: "const_low",  pat: 0, exp_first: 0,  exp_steady: 0};
      vecs[3] = '{name: "pulse_4",    pat: 3, exp_first: 4,  exp_steady: 4};

      do_reset();
      chk("reset_dout", int'(bus.dout), 0);
      chk("reset_valid", int'(bus.dout_valid), 0);
      chk("reset_ovr", int'(bus.ovr), 0);

      // Density table, consumer always ready.
      for (int v = 0; v < 4; v++) begin
         do_reset();
         $display("vector %s", vecs[v].name);
         bus.dout_ready = 1'b1;
         last_pop = -1;
         mon_en = 1'b1;
         exp_q.push_back(vecs[v].exp_first);
         exp_q.push_back(vecs[v].exp_steady);
         exp_q.push_back(vecs[v].exp_steady);
         en = 1'b1;
         ota_out = pat_bit(vecs[v].pat, 0);
         for (int k = 0; k < 49; k++) begin
            tick();
            ota_out = pat_bit(vecs[v].pat, k + 1);
         end
         en = 1'b0;
         ota_out = 1'b0;
         mon_en = 1'b0;
         chk("sb_drained", exp_q.size(), 0);
         exp_q.delete();
      end

      // Backpressure, overrun, clear, set-beats-clear, then load/consume collision.
      do_reset();
      en = 1'b1;
      ota_out = 1'b1;
      ticks(16);
      chk("bp_first_valid", int'(bus.dout_valid), 1);
      chk("bp_first_dout", int'(bus.dout), 14);
      chk("bp_first_ovr", int'(bus.ovr), 0);
      ticks(16);
      chk("bp_ovr_set", int'(bus.ovr), 1);
      chk("bp_hold_dout", int'(bus.dout), 14);
      chk("bp_hold_valid", int'(bus.dout_valid), 1);
      ticks(2);
      bus.ovr_clr = 1'b1;
      tick();
      bus.ovr_clr = 1'b0;
      chk("bp_ovr_clr", int'(bus.ovr), 0);
      ticks(12);
      bus.ovr_clr = 1'b1;
      tick();
      bus.ovr_clr = 1'b0;
      chk("bp_set_wins", int'(bus.ovr), 1);
      bus.dout_ready = 1'b1;
      bus.ovr_clr = 1'b1;
      tick();
      bus.dout_ready = 1'b0;
      bus.ovr_clr = 1'b0;
      $display("consume dout=%0d valid=%0d ovr=%0d", bus.dout, bus.dout_valid, bus.ovr);
      chk("bp_consumed_valid", int'(bus.dout_valid), 0);
      chk("bp_consumed_dout", int'(bus.dout), 14);
      chk("bp_consumed_ovr", int'(bus.ovr), 0);
      ticks(15);
      chk("col_full_valid", int'(bus.dout_valid), 1);
      chk("col_full_dout", int'(bus.dout), 16);
      ota_out = 1'b0;
      ticks(15);
      bus.dout_ready = 1'b1;
      tick();
      bus.dout_ready = 1'b0;
      $display("collision dout=%0d valid=%0d ovr=%0d", bus.dout, bus.dout_valid, bus.ovr);
      chk("col_valid", int'(bus.dout_valid), 1);
      chk("col_dout", int'(bus.dout), 2);
      chk("col_ovr", int'(bus.ovr), 0);

      // Abort at slot 9, then a fresh full window.
      do_reset();
      en = 1'b1;
      ota_out = 1'b1;
      ticks(9);
      en = 1'b0;
      ticks(10);
      chk("abort_valid", int'(bus.dout_valid), 0);
      chk("abort_ovr", int'(bus.ovr), 0);
      en = 1'b1;
      ticks(15);
      chk("abort_no_early", int'(bus.dout_valid), 0);
      tick();
      $display("abort refill dout=%0d valid=%0d", bus.dout, bus.dout_valid);
      chk("abort_refill_valid", int'(bus.dout_valid), 1);
      chk("abort_refill_dout", int'(bus.dout), 16);
      ticks(16);
      chk("abort_ovr_later", int'(bus.ovr), 1);

      // Asynchronous reset mid-window clears outputs before any clock edge.
      ticks(5);
      #2;
      rst = 1'b1;
      #1;
      $display("async reset dout=%0d valid=%0d ovr=%0d", bus.dout, bus.dout_valid, bus.ovr);
      chk("arst_dout", int'(bus.dout), 0);
      chk("arst_valid", int'(bus.dout_valid), 0);
      chk("arst_ovr", int'(bus.ovr), 0);
      #1;
      rst = 1'b0;
      bus.dout_ready = 1'b1;
      ticks(15);
      chk("arst_no_partial", int'(bus.dout_valid), 0);
      tick();
      chk("arst_restart_valid", int'(bus.dout_valid), 1);
      chk("arst_restart_dout", int'(bus.dout), 14);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
